divide_dispatch: RTL and testbench

DIVIDE_DISPATCH -- requirements
Module: divide_dispatch

---
 rtl/divide_dispatch_pkg.sv | 28 ++
 rtl/divide_dispatch_fifo.sv | 59 +++++
 rtl/divide_dispatch.sv | 180 ++++++++++++++++++
 tb/tb_divide_dispatch.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/divide_dispatch_pkg.sv
// Shared definitions for the divide dispatcher: controller state encoding
// and the default operand width, queue depth and WAIT timeout.
package divide_dispatch_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  // Cycle budget granted to the divider: a little more than four cycles per
  // operand bit, enough for a bit-serial signed divider plus sign fix-up.
  function automatic int timeout_for(input int width);
    return 4 * width + 8;
  endfunction

  localparam int DEF_TIMEOUT = timeout_for(DEF_WIDTH);

  // Dispatcher controller states.
  //   ST_IDLE  : waiting for an operand pair and a free divider
  //   ST_ISSUE : one-cycle start pulse towards the divider
  //   ST_WAIT  : divider running, watched by the timeout counter
  //   ST_HOLD  : result presented until the consumer takes it
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/divide_dispatch_fifo.sv
// Synchronous operand FIFO with show-ahead read port. A push while full and a
// pop while empty are dropped, so neither can disturb pointers or occupancy.
module sync_fifo
  import divide_dispatch_pkg::*;
#(
  parameter int WIDTH = 2 * DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (AW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two; simultaneous
  // push and pop leave the occupancy untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage holds data only; stale entries are unreachable after reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/divide_dispatch.sv
// Divide dispatcher: queues signed operand pairs, feeds them one at a time to
// an external signed divider, short-circuits divide-by-zero, guards the
// divider with a timeout and presents each result with a valid/ready
// handshake. Results leave strictly in push order, one operation in flight.
module divide_dispatch
  import divide_dispatch_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = timeout_for(WIDTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  // operand push
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [WIDTH-1:0]     in_a,
  input  logic signed [WIDTH-1:0]     in_b,
  // divider side
  output logic signed [WIDTH-1:0]     div_a,
  output logic signed [WIDTH-1:0]     div_b,
  output logic                        div_start,
  input  logic                        div_wait,
  input  logic                        div_done,
  input  logic signed [WIDTH-1:0]     div_result,
  input  logic signed [2*WIDTH-1:0]   div_remainder,
  // result pop
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [WIDTH-1:0]     out_quot,
  output logic signed [2*WIDTH-1:0]   out_rem,
  output logic                        out_dbz,
  output logic                        out_tmo,
  output logic [$clog2(DEPTH):0]      fifo_count
);

  // Counter only has to reach TIMEOUT-1: the expiry decision is taken on the
  // cycle that would make it TIMEOUT.
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  state_e                     state_q, state_d;
  logic [TW-1:0]              tmo_cnt_q, tmo_cnt_d;
  logic signed [WIDTH-1:0]    div_a_q, div_a_d;
  logic signed [WIDTH-1:0]    div_b_q, div_b_d;
  logic signed [WIDTH-1:0]    quot_q, quot_d;
  logic signed [2*WIDTH-1:0]  rem_q, rem_d;
  logic                       dbz_q, dbz_d;
  logic                       tmo_q, tmo_d;

  logic                       fifo_push;
  logic                       fifo_pop;
  logic [2*WIDTH-1:0]         fifo_rdata;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic signed [WIDTH-1:0]    head_a;
  logic signed [WIDTH-1:0]    head_b;

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && !fifo_full;
  assign head_a    = $signed(fifo_rdata[2*WIDTH-1:WIDTH]);
  assign head_b    = $signed(fifo_rdata[WIDTH-1:0]);

  sync_fifo #(
    .WIDTH (2 * WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .wdata_i ({in_a, in_b}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Next-state, pop decision and result capture for the dispatch controller.
  always_comb begin
    state_d   = state_q;
    tmo_cnt_d = '0;
    div_a_d   = div_a_q;
    div_b_d   = div_b_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dbz_d     = dbz_q;
    tmo_d     = tmo_q;
    fifo_pop  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // A divider still busy (e.g. from before a reset) is never overlapped.
        if (!fifo_empty && !div_wait) begin
          fifo_pop = 1'b1;
          div_a_d  = head_a;
          div_b_d  = head_b;
          if (head_b == '0) begin
            quot_d  = '0;
            rem_d   = '0;
            dbz_d   = 1'b1;
            tmo_d   = 1'b0;
            state_d = ST_HOLD;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (div_done) begin
          quot_d  = div_result;
          rem_d   = div_remainder;
          dbz_d   = 1'b0;
          tmo_d   = 1'b0;
          state_d = ST_HOLD;
        end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
          quot_d  = '0;
          rem_d   = '0;
          dbz_d   = 1'b0;
          tmo_d   = 1'b1;
          state_d = ST_HOLD;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end

      ST_HOLD: begin
        if (out_ready) state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Controller state and WAIT timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // Operand and result registers; cleared on reset so the outputs are known.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_a_q <= '0;
      div_b_q <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      div_a_q <= div_a_d;
      div_b_q <= div_b_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      tmo_q   <= tmo_d;
    end
  end

  assign div_start = (state_q == ST_ISSUE);
  assign out_valid = (state_q == ST_HOLD);
  assign div_a     = div_a_q;
  assign div_b     = div_b_q;
  assign out_quot  = quot_q;
  assign out_rem   = rem_q;
  assign out_dbz   = dbz_q;
  assign out_tmo   = tmo_q;

endmodule

// File: tb/tb_divide_dispatch.sv
// Bench for divide_dispatch: directed latency/corner sequences, a vector
// table, and randomized traffic against an operand-queue reference model.
module tb_divide_dispatch;

  localparam int W   = 8;
  localparam int D   = 4;
  localparam int TMO = 4 * W + 8;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic signed [W-1:0]    in_a, in_b;
  logic signed [W-1:0]    div_a, div_b;
  logic                   div_start;
  logic                   div_wait, div_done;
  logic signed [W-1:0]    div_result;
  logic signed [2*W-1:0]  div_remainder;
  logic                   out_valid, out_ready;
  logic signed [W-1:0]    out_quot;
  logic signed [2*W-1:0]  out_rem;
  logic                   out_dbz, out_tmo;
  logic [$clog2(D):0]     fifo_count;

  divide_dispatch #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .div_a(div_a), .div_b(div_b), .div_start(div_start),
    .div_wait(div_wait), .div_done(div_done),
    .div_result(div_result), .div_remainder(div_remainder),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quot(out_quot), .out_rem(out_rem), .out_dbz(out_dbz), .out_tmo(out_tmo),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endfunction

  // Reference model: queue of accepted operand pairs, answered in order.
  typedef struct { int a; int b; } op_t;
  op_t model_q[$];

  function automatic void compare_model(string tag);
    op_t op;
    int  qi, ri;
    logic signed [W-1:0] qt;
    if (model_q.size() == 0) begin
      chk({tag, "_unexpected"}, 1, 0);
      return;
    end
    op = model_q.pop_front();
    if (op.b == 0) begin
      chk({tag, "_quot"}, int'(out_quot), 0);
      chk({tag, "_rem"}, int'(out_rem), 0);
      chk({tag, "_dbz"}, int'(out_dbz), 1);
    end else begin
      qi = op.a / op.b;
      qt = qi[W-1:0];
      ri = op.a % op.b;
      chk({tag, "_quot"}, int'(out_quot), int'(qt));
      chk({tag, "_rem"}, int'(out_rem), ri);
      chk({tag, "_dbz"}, int'(out_dbz), 0);
    end
    chk({tag, "_tmo"}, int'(out_tmo), 0);
  endfunction

  // Divider stand-in. Mode 0: answers after a latency; 1: stays busy forever;
  // 2: div_* follow the man_* variables driven by the main sequence.
  int  dv_mode = 0;
  int  lat_cfg = 1;
  bit  lat_rand = 1'b0;
  bit  man_wait = 1'b0, man_done = 1'b0;
  int  man_res = 0;
  bit  busy = 1'b0;
  int  cap_a, cap_b, rem_lat;
  int  start_cnt = 0;

  initial begin
    int qi, ri;
    div_wait = 1'b0; div_done = 1'b0; div_result = '0; div_remainder = '0;
    forever begin
      @(negedge clk);
      if (dv_mode == 2) begin
        busy = 1'b0;
        div_wait = man_wait;
        div_done = man_done;
        div_result = W'(man_res);
        div_remainder = (2 * W)'(man_res);
      end else begin
        div_done = 1'b0;
        if (div_start) begin
          chk("no_overlap", int'(busy), 0);
          busy = 1'b1;
          cap_a = int'(div_a);
          cap_b = int'(div_b);
          rem_lat = lat_rand ? int'($urandom_range(1, 6)) : lat_cfg;
          div_wait = 1'b1;
        end else if (busy) begin
          chk("div_a_held", int'(div_a), cap_a);
          chk("div_b_held", int'(div_b), cap_b);
          if (dv_mode == 0) begin
            rem_lat--;
            if (rem_lat <= 0) begin
              qi = (cap_b == 0) ? 0 : cap_a / cap_b;
              ri = (cap_b == 0) ? 0 : cap_a % cap_b;
              div_result = qi[W-1:0];
              div_remainder = ri[2*W-1:0];
              div_done = 1'b1;
              div_wait = 1'b0;
              busy = 1'b0;
            end
          end
        end else begin
          div_wait = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (div_start) start_cnt++;
    end
  end

  task automatic push(input int a, input int b);
    int n = 0;
    in_valid = 1'b1;
    in_a = a[W-1:0];
    in_b = b[W-1:0];
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("push_accepted", int'(in_ready), 1);
    if (in_ready) model_q.push_back('{a: a, b: b});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!out_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid_seen", int'(out_valid), 1);
  endtask

  task automatic wait_start();
    int n = 0;
    while (!div_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("div_start_seen", int'(div_start), 1);
  endtask

  task automatic take_result(input bit use_model);
    if (use_model) compare_model("res");
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_drop", int'(out_valid), 0);
  endtask

  typedef struct { int a; int b; int lat; int q; int r; bit dbz; } vec_t;
  vec_t tbl[8];

  localparam int NRAND = 60;

  initial begin
    int n, s0;
    tbl[0] = '{a: 90,   b: 40,  lat: 3, q: 2,    r: 10, dbz: 1'b0};
    tbl[1] = '{a: -90,  b: 40,  lat: 2, q: -2,   r: -10, dbz: 1'b0};
    tbl[2] = '{a: 5,    b: 0,   lat: 1, q: 0,    r: 0,  dbz: 1'b1};
    tbl[3] = '{a: 100,  b: -7,  lat: 1, q: -14,  r: 2,  dbz: 1'b0};
    tbl[4] = '{a: -128, b: -1,  lat: 5, q: -128, r: 0,  dbz: 1'b0};
    tbl[5] = '{a: 127,  b: 127, lat: 4, q: 1,    r: 0,  dbz: 1'b0};
    tbl[6] = '{a: -7,   b: 2,   lat: 6, q: -3,   r: -1, dbz: 1'b0};
    tbl[7] = '{a: 0,    b: -5,  lat: 2, q: 0,    r: 0,  dbz: 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_fifo_count", int'(fifo_count), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_div_start", int'(div_start), 0);
    chk("rst_div_a", int'(div_a), 0);
    chk("rst_div_b", int'(div_b), 0);
    chk("rst_out_quot", int'(out_quot), 0);
    chk("rst_out_rem", int'(out_rem), 0);
    chk("rst_out_dbz", int'(out_dbz), 0);
    chk("rst_out_tmo", int'(out_tmo), 0);
    rst = 1'b0;
    @(negedge clk);

    // Latency with empty FIFO: pop one edge after push, start pulse for one cycle.
    lat_cfg = 3;
    push(90, 40);
    chk("lat_count_after_push", int'(fifo_count), 1);
    chk("lat_no_start_yet", int'(div_start), 0);
    @(negedge clk);
    chk("lat_start_pulse", int'(div_start), 1);
    chk("lat_count_after_pop", int'(fifo_count), 0);
    chk("lat_div_a", int'(div_a), 90);
    chk("lat_div_b", int'(div_b), 40);
    @(negedge clk);
    chk("lat_start_single", int'(div_start), 0);
    wait_valid(100);
    chk("lat_quot", int'(out_quot), 2);
    chk("lat_rem", int'(out_rem), 10);
    take_result(1'b1);

    // Divide-by-zero: result one edge after the pop edge, divider untouched.
    s0 = start_cnt;
    push(5, 0);
    chk("dbz_not_yet_valid", int'(out_valid), 0);
    @(negedge clk);
    chk("dbz_valid", int'(out_valid), 1);
    chk("dbz_flag", int'(out_dbz), 1);
    chk("dbz_quot", int'(out_quot), 0);
    chk("dbz_rem", int'(out_rem), 0);
    chk("dbz_no_start", int'(div_start), 0);
    take_result(1'b1);
    chk("dbz_start_count", start_cnt - s0, 0);

    // Vector table.
    for (int i = 0; i < 8; i++) begin
      lat_cfg = tbl[i].lat;
      s0 = start_cnt;
      push(tbl[i].a, tbl[i].b);
      wait_valid(100);
      chk("tbl_quot", int'(out_quot), tbl[i].q);
      chk("tbl_rem", int'(out_rem), tbl[i].r);
      chk("tbl_dbz", int'(out_dbz), int'(tbl[i].dbz));
      chk("tbl_tmo", int'(out_tmo), 0);
      chk("tbl_starts", start_cnt - s0, tbl[i].dbz ? 0 : 1);
      take_result(1'b1);
    end

    // Back-to-back pushes with the consumer stalled fill the FIFO.
    lat_cfg = 2;
    for (int i = 0; i < 5; i++) push(10 * i + 13, i - 2);
    chk("full_count", int'(fifo_count), 4);
    chk("full_in_ready", int'(in_ready), 0);
    in_valid = 1'b1; in_a = 8'sd77; in_b = 8'sd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_push_blocked", int'(fifo_count), 4);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_valid(100);
      take_result(1'b1);
    end
    chk("drain_count", int'(fifo_count), 0);
    chk("drain_model_empty", model_q.size(), 0);

    // Divider never finishes: timeout exactly TMO cycles after entering WAIT.
    dv_mode = 1;
    push(33, 4);
    wait_start();
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("tmo_cycles", n, TMO);
    chk("tmo_flag", int'(out_tmo), 1);
    chk("tmo_dbz", int'(out_dbz), 0);
    chk("tmo_quot", int'(out_quot), 0);
    chk("tmo_rem", int'(out_rem), 0);
    void'(model_q.pop_front());
    man_wait = 1'b0; man_done = 1'b0; dv_mode = 2;
    take_result(1'b0);
    @(negedge clk);
    dv_mode = 0;
    @(negedge clk);

    // Reset mid-WAIT while the divider stays busy; stale strobe ignored.
    lat_cfg = 30;
    push(50, 7);
    wait_start();
    repeat (3) @(negedge clk);
    man_wait = 1'b1; man_done = 1'b0; man_res = 99; dv_mode = 2;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_count", int'(fifo_count), 0);
    chk("mid_rst_div_a", int'(div_a), 0);
    chk("mid_rst_div_start", int'(div_start), 0);
    model_q.delete();
    push(60, 6);
    for (int i = 0; i < 10; i++) begin
      man_done = (i == 3);
      chk("busy_no_start", int'(div_start), 0);
      chk("busy_no_valid", int'(out_valid), 0);
      chk("busy_no_pop", int'(fifo_count), 1);
      @(negedge clk);
    end
    man_done = 1'b0; man_wait = 1'b0;
    @(negedge clk);
    dv_mode = 0;
    lat_cfg = 2;
    wait_valid(100);
    take_result(1'b1);

    // Randomized traffic against the reference model.
    lat_rand = 1'b1;
    fork
      begin
        int i = 0, t = 0;
        logic signed [W-1:0] ra, rb;
        while (i < NRAND && t < 5000) begin
          @(negedge clk);
          t++;
          if ($urandom_range(0, 2) != 0) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
            in_valid = 1'b1;
            in_a = ra;
            in_b = rb;
            if (in_ready) begin
              model_q.push_back('{a: int'(ra), b: int'(rb)});
              i++;
            end
          end else begin
            in_valid = 1'b0;
          end
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin
        int got = 0, cyc = 0;
        bit r;
        while (got < NRAND && cyc < 8000) begin
          @(negedge clk);
          cyc++;
          r = 1'($urandom_range(0, 1));
          out_ready = r;
          if (out_valid && r) begin
            compare_model("rand");
            got++;
          end
        end
        @(negedge clk);
        out_ready = 1'b0;
        chk("rand_all_results", got, NRAND);
      end
    join
    chk("rand_model_empty", model_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
